// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - instruction/data bus arbiter for a single memory port
module mem_bus_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,
   input  logic        dreq_valid,
   input  logic [63:0] dreq_addr,
   input  logic [2:0]  dreq_size,
   input  logic [7:0]  dreq_strobe,
   input  logic [63:0] dreq_data,
   output logic        dresp_data_ok,
   output logic [63:0] dresp_data,
   output logic        mreq_valid,
   output logic [63:0] mreq_addr,
   output logic [2:0]  mreq_size,
   output logic [7:0]  mreq_strobe,
   output logic [63:0] mreq_data,
   input  logic        mresp_data_ok,
   input  logic [63:0] mresp_data
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          mreq_valid_q, mreq_valid_d;
   logic [63:0]   mreq_addr_q, mreq_addr_d;
   logic [2:0]    mreq_size_q, mreq_size_d;
   logic [7:0]    mreq_strobe_q, mreq_strobe_d;
   logic [63:0]   mreq_data_q, mreq_data_d;
   logic          d_wins;

   // Arbitration, request latching and streak bookkeeping
   always_comb begin
      state_d       = state_q;
      streak_d      = streak_q;
      mreq_valid_d  = mreq_valid_q;
      mreq_addr_d   = mreq_addr_q;
      mreq_size_d   = mreq_size_q;
      mreq_strobe_d = mreq_strobe_q;
      mreq_data_d   = mreq_data_q;
      // Data bus wins unless a fetch has already waited out a full streak
      d_wins        = dreq_valid && !(ireq_valid && (streak_q == STREAK_MAX));
      case (state_q)
         IDLE: begin
            if (!ireq_valid) begin
               streak_d = '0;
            end
            if (d_wins) begin
               state_d       = BUSY_D;
               mreq_valid_d  = 1'b1;
               mreq_addr_d   = dreq_addr;
               mreq_size_d   = dreq_size;
               mreq_strobe_d = dreq_strobe;
               mreq_data_d   = dreq_data;
               if (ireq_valid && (streak_q != STREAK_MAX)) begin
                  streak_d = streak_q + SW'(1);
               end
            end else if (ireq_valid) begin
               state_d       = BUSY_I;
               mreq_valid_d  = 1'b1;
               mreq_addr_d   = ireq_addr;
               mreq_size_d   = 3'b010;
               mreq_strobe_d = 8'h00;
               mreq_data_d   = 64'h0;
               streak_d      = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            // Always pass through IDLE so the requester can drop valid
            if (mresp_data_ok) begin
               state_d      = IDLE;
               mreq_valid_d = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            mreq_valid_d = 1'b0;
         end
      endcase
   end

   // State and latched memory request registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         streak_q      <= '0;
         mreq_valid_q  <= 1'b0;
         mreq_addr_q   <= 64'h0;
         mreq_size_q   <= 3'b000;
         mreq_strobe_q <= 8'h00;
         mreq_data_q   <= 64'h0;
      end else begin
         state_q       <= state_d;
         streak_q      <= streak_d;
         mreq_valid_q  <= mreq_valid_d;
         mreq_addr_q   <= mreq_addr_d;
         mreq_size_q   <= mreq_size_d;
         mreq_strobe_q <= mreq_strobe_d;
         mreq_data_q   <= mreq_data_d;
      end
   end

   // Completion pulses steer the memory response back to the owning bus
   always_comb begin
      iresp_data_ok = (state_q == BUSY_I) && mresp_data_ok;
      dresp_data_ok = (state_q == BUSY_D) && mresp_data_ok;
      iresp_data    = 32'h0;
      dresp_data    = 64'h0;
      if (iresp_data_ok) begin
         iresp_data = mreq_addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
      end
      if (dresp_data_ok) begin
         dresp_data = mresp_data;
      end
   end

   assign mreq_valid  = mreq_valid_q;
   assign mreq_addr   = mreq_addr_q;
   assign mreq_size   = mreq_size_q;
   assign mreq_strobe = mreq_strobe_q;
   assign mreq_data   = mreq_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int MAXS = 4;
   localparam logic [63:0] MDATA = 64'hAAAA_BBBB_CCCC_DDDD;
   localparam logic [63:0] IADDR = 64'h0000_0000_8000_0004;
   localparam logic [63:0] DADDR = 64'h0000_0000_8000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        iv, dv, mok;
   logic [63:0] iaddr, daddr, ddata, mdata;
   logic [2:0]  dsize;
   logic [7:0]  dstrobe;
   logic        iok, dok, mv;
   logic [31:0] idata;
   logic [63:0] dresp, maddr, mdat;
   logic [2:0]  msize;
   logic [7:0]  mstrb;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(.MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(iv), .ireq_addr(iaddr),
      .iresp_data_ok(iok), .iresp_data(idata),
      .dreq_valid(dv), .dreq_addr(daddr), .dreq_size(dsize),
      .dreq_strobe(dstrobe), .dreq_data(ddata),
      .dresp_data_ok(dok), .dresp_data(dresp),
      .mreq_valid(mv), .mreq_addr(maddr), .mreq_size(msize),
      .mreq_strobe(mstrb), .mreq_data(mdat),
      .mresp_data_ok(mok), .mresp_data(mdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        dv;
      logic        mok;
      logic        e_mv;
      logic        e_iok;
      logic        e_dok;
      logic [7:0]  e_strb;
      logic [63:0] e_addr;
   } vec_t;

   vec_t tbl [0:8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      iv = 0; dv = 0; mok = 0;
      iaddr = 0; daddr = 0; dsize = 0; dstrobe = 0; ddata = 0; mdata = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // reference model state: owner 0 = none, 1 = fetch, 2 = data
   int          m_owner;
   int          m_streak;
   logic [63:0] m_addr, m_data;
   logic [2:0]  m_size;
   logic [7:0]  m_strb;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          seq[$];
      logic        e_iok, e_dok, drop_i, drop_d;
      logic [31:0] e_idata;

      // Test 1/2: reset with fetch pending, then a 3-cycle fetch
      reset = 1'b0;
      dv = 0; mok = 0; daddr = 0; dsize = 0; dstrobe = 0; ddata = 0; mdata = 0;
      iv = 1; iaddr = IADDR;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t1_rst_mv", mv, 0);
      chk("t1_rst_addr", maddr, 0);
      chk("t1_rst_iok", iok, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t1_mv", mv, 1);
      chk("t1_size", msize, 3'b010);
      chk("t1_addr", maddr, IADDR);
      chk("t1_strb", mstrb, 0);
      chk("t1_data", mdat, 0);
      for (int c = 0; c < 3; c++) begin
         mok = (c == 2);
         mdata = MDATA;
         @(negedge clk);
         chk($sformatf("t2_iok%0d", c), iok, (c == 2));
         chk($sformatf("t2_dok%0d", c), dok, 0);
         if (c == 2) chk("t2_idata", idata, 32'hAAAA_BBBB);
         @(posedge clk); #1;
      end
      iv = 0; mok = 0;
      @(negedge clk);
      chk("t2_idle_mv", mv, 0);
      chk("t2_idle_iok", iok, 0);
      @(posedge clk); #1;

      // Table-driven vectors: priority, IDLE gap, late response ignored
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, DADDR};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, DADDR};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, IADDR};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, DADDR};
      tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0};
      do_reset();
      iaddr = IADDR; daddr = DADDR; dstrobe = 8'hFF; dsize = 3'b011;
      ddata = 64'h1122_3344_5566_7788; mdata = MDATA;
      for (int i = 0; i < 9; i++) begin
         iv = tbl[i].iv; dv = tbl[i].dv; mok = tbl[i].mok;
         @(negedge clk);
         chk($sformatf("vec%0d_mv", i), mv, tbl[i].e_mv);
         chk($sformatf("vec%0d_iok", i), iok, tbl[i].e_iok);
         chk($sformatf("vec%0d_dok", i), dok, tbl[i].e_dok);
         if (tbl[i].e_mv) begin
            chk($sformatf("vec%0d_strb", i), mstrb, tbl[i].e_strb);
            chk($sformatf("vec%0d_addr", i), maddr, tbl[i].e_addr);
         end
         if (tbl[i].e_iok) chk($sformatf("vec%0d_idata", i), idata, 32'hAAAA_BBBB);
         if (tbl[i].e_dok) chk($sformatf("vec%0d_ddata", i), dresp, MDATA);
         @(posedge clk); #1;
      end

      // Test 4: both requesters held, streak limit lets fetch through
      do_reset();
      iv = 1; iaddr = 64'h8000_0008; dv = 1; daddr = 64'h10; mdata = MDATA;
      for (int c = 0; c < 200 && seq.size() < 10; c++) begin
         mok = mv;
         @(negedge clk);
         if (iok) seq.push_back(1);
         if (dok) seq.push_back(2);
         @(posedge clk); #1;
      end
      iv = 0; dv = 0; mok = 0;
      chk("t4_count", seq.size(), 10);
      for (int k = 0; k < seq.size(); k++)
         chk($sformatf("t4_grant%0d", k), seq[k], ((k % 5) == 4) ? 1 : 2);

      // Test 5: reset in BUSY_D drops the transaction
      do_reset();
      dv = 1; daddr = 64'h8000_2000; dstrobe = 8'h0F; dsize = 3'b011;
      @(posedge clk); #1;
      chk("t5_busy_mv", mv, 1);
      chk("t5_busy_strb", mstrb, 8'h0F);
      #2 reset = 1'b0;
      #1;
      chk("t5_rst_mv", mv, 0);
      chk("t5_rst_addr", maddr, 0);
      chk("t5_rst_strb", mstrb, 0);
      dv = 0; mok = 1; mdata = MDATA;
      #1;
      chk("t5_rst_dok", dok, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_late_dok", dok, 0);
      chk("t5_late_iok", iok, 0);
      @(posedge clk); #1;
      chk("t5_idle_mv", mv, 0);
      mok = 0;

      // Test 6: requester changes do not disturb the latched request
      do_reset();
      dv = 1; daddr = 64'h8000_3000; dstrobe = 8'h00; dsize = 3'b011;
      @(posedge clk); #1;
      daddr = 64'h8000_3008; dstrobe = 8'h3C;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("t6_addr%0d", c), maddr, 64'h8000_3000);
         chk($sformatf("t6_strb%0d", c), mstrb, 8'h00);
         @(posedge clk); #1;
      end
      mok = 1; mdata = MDATA;
      @(negedge clk);
      chk("t6_dok", dok, 1);
      chk("t6_addr_done", maddr, 64'h8000_3000);
      @(posedge clk); #1;
      dv = 0; mok = 0;
      @(negedge clk);
      chk("t6_idle_mv", mv, 0);
      @(posedge clk); #1;

      // Randomized traffic against a transaction-level reference model
      do_reset();
      m_owner = 0; m_streak = 0;
      m_addr = 0; m_data = 0; m_size = 0; m_strb = 0;
      drop_i = 0; drop_d = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!iv && !drop_i) iv = ($urandom_range(1, 0) == 1);
         if (!dv && !drop_d) dv = ($urandom_range(3, 0) != 0);
         drop_i = 0; drop_d = 0;
         iaddr = {$urandom(), $urandom() & 32'hFFFF_FFFC};
         daddr = {$urandom(), $urandom()};
         ddata = {$urandom(), $urandom()};
         dsize = 3'($urandom_range(7, 0));
         dstrobe = 8'($urandom_range(255, 0));
         mdata = {$urandom(), $urandom()};
         if (m_owner != 0) mok = ($urandom_range(2, 0) == 0);
         else mok = ($urandom_range(7, 0) == 0);
         e_iok = (m_owner == 1) && mok;
         e_dok = (m_owner == 2) && mok;
         e_idata = m_addr[2] ? mdata[63:32] : mdata[31:0];
         @(negedge clk);
         chk("rnd_mv", mv, (m_owner != 0));
         chk("rnd_iok", iok, e_iok);
         chk("rnd_dok", dok, e_dok);
         if (m_owner != 0) begin
            chk("rnd_addr", maddr, m_addr);
            chk("rnd_size", msize, m_size);
            chk("rnd_strb", mstrb, m_strb);
            chk("rnd_data", mdat, m_data);
         end
         if (e_iok) chk("rnd_idata", idata, e_idata);
         if (e_dok) chk("rnd_ddata", dresp, mdata);
         @(posedge clk);
         if (m_owner == 0) begin
            if (dv && !(iv && m_streak == MAXS)) begin
               m_owner = 2;
               m_addr = daddr; m_size = dsize; m_strb = dstrobe; m_data = ddata;
               m_streak = iv ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (iv) begin
               m_owner = 1;
               m_addr = iaddr; m_size = 3'b010; m_strb = 8'h00; m_data = 64'h0;
               m_streak = 0;
            end else begin
               m_streak = 0;
            end
         end else if (mok) begin
            m_owner = 0;
         end
         #1;
         if (e_iok) begin iv = 0; drop_i = 1; end
         if (e_dok) begin dv = 0; drop_d = 1; end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
